// File: rtl/fb_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_loader_if : stream, fill-request and RAM-write bundle for fb_loader|
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
interface fb_loader_if #(
  parameter int ADDR_W = 14
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_sof;
  logic              s_ready;
  logic              clear_req;
  logic [7:0]        clear_data;
  logic              frame_tick;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              disp_page;
  logic              busy;
  logic              frame_done;

  modport master (
    output s_valid, s_data, s_sof, clear_req, clear_data, frame_tick,
    input  s_ready, we, addr, wdata, disp_page, busy, frame_done
  );

  modport slave (
    input  s_valid, s_data, s_sof, clear_req, clear_data, frame_tick,
    output s_ready, we, addr, wdata, disp_page, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fb_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_loader : 1bpp byte-stream loader into a bitmap RAM back page, with |
// |             hardware fill and frame-boundary page swap.               |
// |             FB_DOUBLE_BUFFER_EN selects two pages + SWAP_WAIT.        |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module fb_loader #(
  parameter int BYTES_PER_LINE = 40,
  parameter int LINES          = 200,
  parameter int ADDR_W         = 14
) (
  input  logic         clk,
  input  logic         rst,
  fb_loader_if.slave   bus
);
  localparam int                N      = BYTES_PER_LINE * LINES;
  localparam logic [ADDR_W-1:0] C_N    = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        fill_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              done_q;
  logic              busy_q;

  logic [ADDR_W-1:0] base_d;
  logic [ADDR_W-1:0] off_d;

`ifdef FB_DOUBLE_BUFFER_EN
  logic disp_q;
  // The back page is whichever one scanout is not reading.
  assign base_d        = disp_q ? '0 : C_N;
  assign bus.disp_page = disp_q;
`else
  logic done_pend_q;
  logic unused_tick;
  assign unused_tick   = bus.frame_tick;
  assign base_d        = '0;
  assign bus.disp_page = 1'b0;
`endif

  assign off_d       = bus.s_sof ? '0 : ptr_q;
  assign bus.s_ready = (state_q == ST_LOAD) && !bus.clear_req;
  assign bus.we         = we_q;
  assign bus.addr       = addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      fill_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      disp_q  <= 1'b0;
`else
      done_pend_q <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      done_q <= 1'b0;
`else
      // Single page: completion trails the final write by one cycle.
      done_q      <= done_pend_q;
      done_pend_q <= 1'b0;
`endif
      case (state_q)
        ST_LOAD: begin
          if (bus.clear_req) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            fill_q  <= bus.clear_data;
            busy_q  <= 1'b1;
          end else if (bus.s_valid) begin
            we_q    <= 1'b1;
            addr_q  <= base_d + off_d;
            wdata_q <= bus.s_data;
            if (off_d == C_LAST) begin
              ptr_q <= '0;
`ifdef FB_DOUBLE_BUFFER_EN
              state_q <= ST_SWAP_WAIT;
              busy_q  <= 1'b1;
`else
              done_pend_q <= 1'b1;
`endif
            end else begin
              ptr_q <= off_d + C_ONE;
            end
          end
        end
        ST_CLEAR: begin
          we_q    <= 1'b1;
          addr_q  <= base_d + ptr_q;
          wdata_q <= fill_q;
          if (ptr_q == C_LAST) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + C_ONE;
          end
        end
`ifdef FB_DOUBLE_BUFFER_EN
        ST_SWAP_WAIT: begin
          if (bus.frame_tick) begin
            disp_q  <= ~disp_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
`endif
        default: begin
          state_q <= ST_LOAD;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fb_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fb_loader : directed, table-driven bench for fb_loader             |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_fb_loader;
  localparam int BPL = 40;
  localparam int LN  = 200;
  localparam int AW  = 14;
  localparam int N   = BPL * LN;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int B0  = N;
`else
  localparam int B0  = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_loader_if #(.ADDR_W(AW)) bus ();

  fb_loader #(.BYTES_PER_LINE(BPL), .LINES(LN), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic        sof;
    logic [7:0]  d;
    logic        e_rdy;
    logic        e_we;
    logic [31:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bad, bad_rdy, bad_done, bad_disp, done_cnt;

    tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, B0 + 0, 8'h11, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 0,      8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, B0 + 1, 8'h22, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, B0 + 2, 8'h33, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, B0 + 0, 8'hAA, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, B0 + 1, 8'h44, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b1, B0 + 2, 8'h55, 1'b0};

    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_sof = 1'b0;
    bus.clear_req = 1'b0; bus.clear_data = 8'h00; bus.frame_tick = 1'b0;
    step(); step();
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_disp", bus.disp_page, 0);
    chk("rst_ready", bus.s_ready, 1);
    rst = 1'b0;
    step();

    // Basic stream, sof restart, idle cycle
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = tbl[i].v; bus.s_sof = tbl[i].sof; bus.s_data = tbl[i].d;
      #1;
      chk($sformatf("v%0d_ready", i), bus.s_ready, tbl[i].e_rdy);
      step();
      chk($sformatf("v%0d_we", i), bus.we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_addr", i), bus.addr, tbl[i].e_addr);
        chk($sformatf("v%0d_wdata", i), bus.wdata, tbl[i].e_wd);
      end
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].e_busy);
    end
    bus.s_sof = 1'b0;

    // Clear with s_valid high: the request cycle accepts nothing
    bus.s_valid = 1'b1; bus.s_data = 8'h77;
    bus.clear_req = 1'b1; bus.clear_data = 8'h5A;
    #1;
    chk("clr_req_ready", bus.s_ready, 0);
    step();
    chk("clr_entry_we", bus.we, 0);
    chk("clr_entry_busy", bus.busy, 1);
    bus.clear_req = 1'b0; bus.clear_data = 8'h00;
    bad = 0; bad_rdy = 0;
    for (int k = 0; k < N; k++) begin
      if (bus.s_ready !== 1'b0) bad_rdy++;
      step();
      if (bus.we !== 1'b1 || bus.addr !== AW'(B0 + k) || bus.wdata !== 8'h5A ||
          bus.busy !== (k < N - 1)) begin
        if (bad == 0)
          $display("FAIL clr_write k=%0d: got we=%0d addr=%0d wdata=%0h busy=%0d expected addr=%0d wdata=5a",
                   k, bus.we, bus.addr, bus.wdata, bus.busy, B0 + k);
        bad++;
      end
    end
    chk("clr_bad_writes", bad, 0);
    chk("clr_ready_low", bad_rdy, 0);
    bus.s_valid = 1'b0;
    #1;
    chk("clr_ready_back", bus.s_ready, 1);
    step();
    chk("clr_after_we", bus.we, 0);
    chk("clr_after_busy", bus.busy, 0);

    // Full frame stream
    bad = 0; bad_rdy = 0; bad_done = 0; bad_disp = 0; done_cnt = 0;
`ifdef FB_DOUBLE_BUFFER_EN
    for (int i = 0; i < N; i++) begin
      bus.s_valid = 1'b1; bus.s_data = i[7:0];
      bus.frame_tick = (i == N - 1);
      #1;
      if (bus.s_ready !== 1'b1) bad_rdy++;
      step();
      if (bus.we !== 1'b1 || bus.addr !== AW'(B0 + i) || bus.wdata !== i[7:0]) bad++;
      if (bus.frame_done !== 1'b0) bad_done++;
      if (bus.disp_page !== 1'b0) bad_disp++;
    end
    chk("frm_bad_writes", bad, 0);
    chk("frm_ready", bad_rdy, 0);
    chk("frm_done_early", bad_done, 0);
    chk("frm_disp_early", bad_disp, 0);
    bus.frame_tick = 1'b0;
    #1;
    chk("sw_ready_low", bus.s_ready, 0);
    chk("sw_busy", bus.busy, 1);
    step();
    chk("sw_we_low", bus.we, 0);
    chk("sw_disp_hold", bus.disp_page, 0);
    step();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk("sw_disp", bus.disp_page, 1);
    chk("sw_done", bus.frame_done, 1);
    chk("sw_ready_up", bus.s_ready, 1);
    chk("sw_busy_low", bus.busy, 0);
    bus.s_data = 8'h3C;
    step();
    chk("sw_next_we", bus.we, 1);
    chk("sw_next_addr", bus.addr, 0);
    chk("sw_next_wdata", bus.wdata, 8'h3C);
    chk("sw_done_drop", bus.frame_done, 0);
`else
    for (int i = 0; i <= N; i++) begin
      bus.s_valid = 1'b1; bus.s_data = i[7:0];
      bus.frame_tick = (i == 100);
      #1;
      if (bus.s_ready !== 1'b1) bad_rdy++;
      step();
      if (bus.we !== 1'b1 || bus.addr !== AW'(i % N) || bus.wdata !== i[7:0]) begin
        if (bad == 0)
          $display("FAIL frm_write i=%0d: got we=%0d addr=%0d wdata=%0h expected addr=%0d wdata=%0h",
                   i, bus.we, bus.addr, bus.wdata, i % N, i[7:0]);
        bad++;
      end
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.frame_done !== (i == N)) bad_done++;
      if (bus.disp_page !== 1'b0) bad_disp++;
      if (bus.busy !== 1'b0) bad_rdy++;
    end
    bus.s_valid = 1'b0; bus.frame_tick = 1'b0;
    step();
    if (bus.frame_done === 1'b1) done_cnt++;
    chk("frm_bad_writes", bad, 0);
    chk("frm_ready_busy", bad_rdy, 0);
    chk("frm_done_timing", bad_done, 0);
    chk("frm_done_count", done_cnt, 1);
    chk("frm_disp_const", bad_disp, 0);
    chk("frm_idle_we", bus.we, 0);
`endif

    // Reset in the middle of a frame
    bus.s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.s_data = i[7:0];
      step();
    end
    rst = 1'b1;
    #1;
    chk("mrst_we", bus.we, 0);
    chk("mrst_addr", bus.addr, 0);
    chk("mrst_wdata", bus.wdata, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.frame_done, 0);
    chk("mrst_disp", bus.disp_page, 0);
    chk("mrst_ready", bus.s_ready, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.s_data = 8'hC3;
    step();
    chk("mrst_next_we", bus.we, 1);
    chk("mrst_next_addr", bus.addr, B0);
    chk("mrst_next_wdata", bus.wdata, 8'hC3);
    bus.s_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
